host_mem_arbiter: RTL and testbench
===================================

Name: host_mem_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one DW-wide host-memory access port between NUM_REQ DMA-style requesters.
- Each requester issues a burst command (read/write, start address, DW count). The winner is locked until its burst finishes.
- The block splits each burst into single-DW memory beats and routes write data and read data.
- It detects MSI-X writes (MSIX_ADDR/MSIX_DATA) and raises a sticky interrupt flag, cleared by the testbench/driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 8, width of burst length field in DWs
MSIX_ADDR, 64'h1, host address that identifies an MSI-X write
MSIX_DATA, 32'h12345678, data value that identifies an MSI-X write

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  burst command pending, held until req_ready
req_ready  out  NUM_REQ  one-hot: command accepted this cycle
req_wr  in  NUM_REQ  1=write burst, 0=read burst
req_addr  in  NUM_REQ*64  start byte address, DW-aligned
req_len  in  NUM_REQ*LEN_W  burst length in DWs; 0 treated as 1
req_wdata  in  NUM_REQ*32  current write DW of each requester
wbeat_ack  out  NUM_REQ  one-hot: requester's current write DW consumed, present next
rdata  out  32  read data (shared)
rdata_valid  out  NUM_REQ  one-hot: rdata belongs to this requester
done  out  NUM_REQ  one-hot one-cycle pulse: burst complete
mem_valid  out  1  beat request to host memory
mem_ready  in  1  memory accepts beat
mem_wr  out  1  beat direction
mem_addr  out  64  beat byte address
mem_wdata  out  32  beat write data
mem_rvalid  in  1  read data return (in order, ≥1 cycle after accept)
mem_rdata  in  32  read data
msix_intr  out  1  sticky MSI-X flag
msix_clr  in  1  clears msix_intr

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE; rr pointer=0 (requester 0 highest priority first); all outputs 0; msix_intr=0. Reset mid-burst abandons the burst, with no done pulse.
- IDLE: if any req_valid, select the first set bit at or after rr pointer (wrapping). Assert req_ready[g] for one cycle. Latch wr/addr/len (len 0 -> 1). Set rr pointer=(g+1)%NUM_REQ. Go to BEAT next cycle. Arbitration latency: 1 cycle from req_valid to req_ready when idle.
- BEAT: mem_valid=1, mem_addr=cur_addr, mem_wr=latched wr, mem_wdata=req_wdata[g] (combinational pass-through). Hold all mem outputs stable until mem_ready.
  - On mem_ready & write: wbeat_ack[g] pulses the same cycle; remaining decrements; cur_addr+=4 (mod 2^64, wrap to 0 allowed).
  - On mem_ready & read: go to RWAIT.
- RWAIT: mem_valid=0. On mem_rvalid: rdata=mem_rdata registered, and rdata_valid[g]=1 the following cycle. Then remaining decrements and cur_addr+=4.
  - mem_rvalid outside RWAIT is ignored.
- After the last beat (write accept or read return): go to DONE. DONE asserts done[g] for one cycle, then IDLE.
  - A requester re-asserting req_valid is arbitrated no earlier than the cycle after done.
- Only one outstanding beat at any time; no requester switching inside a burst.
- A requester dropping req_valid before req_ready is legal; it is simply not selected.
- MSI-X: on a write beat accepted with mem_addr==MSIX_ADDR and mem_wdata==MSIX_DATA, msix_intr=1 from the next cycle.
  - msix_clr=1 clears it next cycle.
  - Simultaneous set and clr: set wins (msix_intr stays 1).
- Throughput: write burst of N DWs with mem_ready tied 1 takes 1 (arb) + N + 1 (done) cycles.

Test Plan:
- Single write: req 0, addr 0x1000, len 3, wdata 0xA,0xB,0xC, mem_ready=1 -> mem beats 0x1000/0xA, 0x1004/0xB, 0x1008/0xC on consecutive cycles; 3 wbeat_ack[0]; done[0] exactly one cycle after the third beat.
- Read with latency: req 2 read addr 0x2000 len 2, mem_rvalid 3 cycles after each accept with 0x11,0x22 -> rdata_valid[2] twice, rdata 0x11 then 0x22; only one mem_valid outstanding; done[2].
- Round-robin fairness: all 4 req_valid held continuously, len 1 each -> grant order 0,1,2,3,0,1 …; no requester granted twice before others.
- Backpressure and wrap: write addr 0xFFFF_FFFF_FFFF_FFFC len 2, mem_ready low 5 cycles on first beat -> mem_addr/mem_wdata stable while stalled; second beat addr 0x0; len 0 request produces exactly 1 beat.
- MSI-X: write burst addr 0x1 data 0x12345678 -> msix_intr=1 the cycle after accept and stays high; msix_clr pulse -> 0. Set and clr in the same cycle -> remains 1. Write 0x1/0x12345679 -> no interrupt.
- Reset mid-burst: rst_n low during beat 2 of a 4-DW read -> all outputs 0 next cycle, no done, rr pointer 0. A new req_valid[1] afterwards is granted normally.

Source files
------------

// File: rtl/host_mem_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ burst commands onto one DW-wide
// host memory port. Bursts are split into single-DW beats, one beat outstanding.

module host_mem_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] pick,
  input  logic [IDX_W-1:0] gnt,
  input  logic             accept,
  input  logic             wack,
  input  logic             rdv,
  input  logic             fin,
  output logic             ready,
  output logic             beat_ack,
  output logic             rd_valid,
  output logic             done
);
  logic own_pick, own_gnt;

  assign own_pick = (pick == IDX_W'(LANE));
  assign own_gnt  = (gnt == IDX_W'(LANE));
  assign ready    = accept & own_pick;
  assign beat_ack = wack & own_gnt;
  assign rd_valid = rdv & own_gnt;
  assign done     = fin & own_gnt;
endmodule

module host_mem_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          LEN_W     = 8,
  parameter logic [63:0] MSIX_ADDR = 64'h1,
  parameter logic [31:0] MSIX_DATA = 32'h12345678
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0][63:0]        req_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0][31:0]        req_wdata,
  output logic [NUM_REQ-1:0]              wbeat_ack,
  output logic [31:0]                     rdata,
  output logic [NUM_REQ-1:0]              rdata_valid,
  output logic [NUM_REQ-1:0]              done,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic                            mem_wr,
  output logic [63:0]                     mem_addr,
  output logic [31:0]                     mem_wdata,
  input  logic                            mem_rvalid,
  input  logic [31:0]                     mem_rdata,
  output logic                            msix_intr,
  input  logic                            msix_clr
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RWAIT, S_DONE} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, gnt, pick, idx_b;
  logic               pick_vld;
  logic               cur_wr;
  logic [63:0]        cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic               rdv_q, msix_q;
  logic               accept, beat_go, wack, rret, last, msix_hit;
  int                 idx;

  // Rotating priority: first pending requester at or after rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    idx_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_b = IDX_W'(idx);
      if (!pick_vld && req_valid[idx_b]) begin
        pick_vld = 1'b1;
        pick     = idx_b;
      end
    end
  end

  assign accept   = rst_n && (state == S_IDLE) && pick_vld;
  assign beat_go  = (state == S_BEAT) && mem_ready;
  assign wack     = beat_go && cur_wr;
  assign rret     = (state == S_RWAIT) && mem_rvalid;
  assign last     = (remaining == LEN_W'(1));
  assign msix_hit = wack && (cur_addr == MSIX_ADDR) && (mem_wdata == MSIX_DATA);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_BEAT;
      S_BEAT:  if (mem_ready) state_nx = cur_wr ? (last ? S_DONE : S_BEAT) : S_RWAIT;
      S_RWAIT: if (mem_rvalid) state_nx = last ? S_DONE : S_BEAT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      rdata     <= '0;
      rdv_q     <= 1'b0;
      msix_q    <= 1'b0;
    end else begin
      state <= state_nx;
      rdv_q <= rret;
      if (accept) begin
        gnt       <= pick;
        rr_ptr    <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
        cur_wr    <= req_wr[pick];
        cur_addr  <= req_addr[pick];
        remaining <= (req_len[pick] == '0) ? LEN_W'(1) : req_len[pick];
      end
      // A beat completes on write accept or on read return.
      if (wack || rret) begin
        remaining <= remaining - LEN_W'(1);
        cur_addr  <= cur_addr + 64'd4;
      end
      if (rret) rdata <= mem_rdata;
      if (msix_hit)      msix_q <= 1'b1;
      else if (msix_clr) msix_q <= 1'b0;
    end
  end

  assign mem_valid = (state == S_BEAT);
  assign mem_wr    = mem_valid && cur_wr;
  assign mem_addr  = mem_valid ? cur_addr : '0;
  assign mem_wdata = mem_wr ? req_wdata[gnt] : '0;
  assign msix_intr = msix_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    host_mem_arbiter_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .pick     (pick),
      .gnt      (gnt),
      .accept   (accept),
      .wack     (wack),
      .rdv      (rdv_q),
      .fin      (state == S_DONE),
      .ready    (req_ready[g]),
      .beat_ack (wbeat_ack[g]),
      .rd_valid (rdata_valid[g]),
      .done     (done[g])
    );
  end
endmodule

// File: tb/tb_host_mem_arbiter.sv
// Randomised bench for host_mem_arbiter: requester/memory drivers plus a
// transaction-level reference model checked every cycle.

module tb_host_mem_arbiter;
  localparam int N  = 4;
  localparam int LW = 8;

  typedef struct packed {
    logic          wr;
    logic [63:0]   addr;
    logic [LW-1:0] len;
    logic [31:0]   dbase;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]          req_valid = '0, req_ready, req_wr = '0;
  logic [N-1:0][63:0]    req_addr = '0;
  logic [N-1:0][LW-1:0]  req_len = '0;
  logic [N-1:0][31:0]    req_wdata = '0;
  logic [N-1:0]          wbeat_ack, rdata_valid, done;
  logic [31:0]           rdata;
  logic                  mem_valid, mem_wr, mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [63:0]           mem_addr;
  logic [31:0]           mem_wdata, mem_rdata = '0;
  logic                  msix_intr, msix_clr = 1'b0;

  always #5 clk = ~clk;

  host_mem_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .wbeat_ack(wbeat_ack), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .msix_intr(msix_intr), .msix_clr(msix_clr)
  );

  int n_chk = 0, n_fail = 0;

  // Requester side
  cmd_t cq[N][$];
  cmd_t cur[N];
  bit   pend[N], rbusy[N];
  int   wcnt[N];

  // Knobs
  int p_ready = 100, p_drop = 0, p_spur = 0, p_clr = 0, lat_lo = 1, lat_hi = 1, stall_n = 0;
  bit clr_hold = 0;

  // Memory side
  bit          rd_pend;
  int          rd_lat;
  logic [63:0] rd_addr;
  logic [31:0] rd_q[$];

  // Reference model of the burst in flight
  bit          m_busy, m_wr, m_rdv, m_msix;
  int          m_g, m_ph, m_rem, m_k, m_rr, m_beats;
  logic [63:0] m_addr;
  logic [31:0] m_rdata;
  int          cyc, grant_cyc, done_cyc, last_beats;
  int          grant_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && !rbusy[i] && cq[i].size() > 0) begin
        cur[i]  = cq[i].pop_front();
        pend[i] = 1;
        wcnt[i] = 0;
      end
      req_valid[i] = pend[i] && !(int'($urandom_range(99)) < p_drop);
      req_wr[i]    = cur[i].wr;
      req_addr[i]  = cur[i].addr;
      req_len[i]   = cur[i].len;
      req_wdata[i] = cur[i].dbase + 32'(wcnt[i]);
    end
    if (stall_n > 0 && m_busy && m_ph == 0) begin
      mem_ready = 1'b0;
      stall_n--;
    end else mem_ready = int'($urandom_range(99)) < p_ready;
    if (rd_pend) begin
      rd_lat--;
      if (rd_lat == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : memf(rd_addr);
        rd_pend    = 0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end else begin
      mem_rvalid = int'($urandom_range(99)) < p_spur;
      mem_rdata  = $urandom;
    end
    msix_clr = clr_hold || (int'($urandom_range(99)) < p_clr);
  endtask

  task automatic sample_check();
    logic [N-1:0] e_rdy;
    bit           found, mset;
    int           p;
    logic [31:0]  wd;
    e_rdy = '0; found = 0; mset = 0; p = 0;
    chk("rdata_valid", 64'(rdata_valid), 64'(m_rdv ? oh(m_g) : '0));
    if (m_rdv) chk("rdata", 64'(rdata), 64'(m_rdata));
    m_rdv = 0;
    if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_rr + i) % N;
        if (!found && req_valid[j]) begin found = 1; p = j; end
      end
      if (found) e_rdy = oh(p);
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("idle_mem_valid", 64'(mem_valid), 64'd0);
      chk("idle_wbeat_ack", 64'(wbeat_ack), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      if (found) begin
        m_busy = 1; m_g = p; m_ph = 0; m_k = 0; m_beats = 0;
        m_addr = cur[p].addr; m_wr = cur[p].wr;
        m_rem  = (cur[p].len == 0) ? 1 : int'(cur[p].len);
        m_rr   = (p + 1) % N;
        pend[p] = 0; rbusy[p] = 1;
        grant_log.push_back(p);
        grant_cyc = cyc;
      end
    end else begin
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      case (m_ph)
        0: begin
          chk("beat_mem_valid", 64'(mem_valid), 64'd1);
          chk("beat_mem_wr", 64'(mem_wr), 64'(m_wr));
          chk("beat_mem_addr", mem_addr, m_addr);
          wd = cur[m_g].dbase + 32'(m_k);
          if (m_wr) chk("beat_mem_wdata", 64'(mem_wdata), 64'(wd));
          chk("beat_done", 64'(done), 64'd0);
          chk("beat_wbeat_ack", 64'(wbeat_ack), 64'((mem_ready && m_wr) ? oh(m_g) : '0));
          if (mem_ready) begin
            if (m_wr) begin
              mset = (m_addr == 64'h1) && (wd == 32'h12345678);
              wcnt[m_g]++; m_k++; m_beats++;
              m_addr = m_addr + 64'd4;
              m_rem--;
              if (m_rem == 0) m_ph = 2;
            end else begin
              m_ph    = 1;
              rd_pend = 1;
              rd_lat  = $urandom_range(lat_hi, lat_lo);
              rd_addr = m_addr;
            end
          end
        end
        1: begin
          chk("rwait_mem_valid", 64'(mem_valid), 64'd0);
          chk("rwait_wbeat_ack", 64'(wbeat_ack), 64'd0);
          chk("rwait_done", 64'(done), 64'd0);
          if (mem_rvalid) begin
            m_rdv = 1; m_rdata = mem_rdata; m_beats++;
            m_addr = m_addr + 64'd4;
            m_rem--;
            m_ph = (m_rem == 0) ? 2 : 0;
          end
        end
        default: begin
          chk("done", 64'(done), 64'(oh(m_g)));
          chk("done_mem_valid", 64'(mem_valid), 64'd0);
          chk("done_wbeat_ack", 64'(wbeat_ack), 64'd0);
          m_busy = 0; rbusy[m_g] = 0;
          done_cyc = cyc; last_beats = m_beats;
        end
      endcase
    end
    chk("msix_intr", 64'(msix_intr), 64'(m_msix));
    m_msix = mset ? 1'b1 : (msix_clr ? 1'b0 : m_msix);
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #4;
    sample_check();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !m_busy && !rd_pend;
    for (int i = 0; i < N; i++) if (pend[i] || cq[i].size() > 0) r = 0;
    return r;
  endfunction

  task automatic run(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      cycle();
      if (all_idle()) begin ok = 1; break; end
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; msix_clr = 1'b0;
    for (int i = 0; i < N; i++) begin cq[i].delete(); pend[i] = 0; rbusy[i] = 0; wcnt[i] = 0; end
    rd_pend = 0; rd_q.delete(); stall_n = 0; clr_hold = 0;
    @(negedge clk);
    #4;
    chk("reset_outputs", 64'({req_ready, wbeat_ack, rdata_valid, done, mem_valid, mem_wr, msix_intr}), 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_data", 64'({rdata, mem_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 0; m_rdv = 0; m_msix = 0; m_rr = 0;
  endtask

  function automatic cmd_t mk(input logic wr, input logic [63:0] a, input int len, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.len = LW'(len); c.dbase = d;
    return c;
  endfunction

  initial begin
    do_reset();

    // Single write burst at full throughput
    cq[0].push_back(mk(1, 64'h1000, 3, 32'hA));
    run(50);
    chk("wr_burst_cycles", 64'(done_cyc - grant_cyc), 64'd4);

    // Read burst with fixed 3-cycle memory latency
    lat_lo = 3; lat_hi = 3;
    rd_q.push_back(32'h11); rd_q.push_back(32'h22);
    cq[2].push_back(mk(0, 64'h2000, 2, 32'h0));
    run(50);
    chk("rd_burst_beats", 64'(last_beats), 64'd2);

    // Round-robin with all requesters pending continuously
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) cq[i].push_back(mk(1, 64'(32'h100 * (i + 1)), 1, $urandom));
    run(100);
    for (int i = 0; i < 2 * N; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % N));

    // First beat back-pressured, address wraps past 2^64, then a zero-length burst
    stall_n = 5;
    cq[1].push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 2, 32'h55));
    run(50);
    chk("wrap_beats", 64'(last_beats), 64'd2);
    cq[3].push_back(mk(1, 64'h4000, 0, 32'h77));
    run(50);
    chk("len0_beats", 64'(last_beats), 64'd1);

    // MSI-X set, clear, set-with-clear, and near-miss data
    do_reset();
    cq[1].push_back(mk(1, 64'h1, 1, 32'h12345678));
    run(50);
    chk("msix_set", 64'(msix_intr), 64'd1);
    clr_hold = 1; cycle(); clr_hold = 0; cycle();
    chk("msix_clr", 64'(msix_intr), 64'd0);
    clr_hold = 1;
    cq[2].push_back(mk(1, 64'h1, 1, 32'h12345678));
    run(50);
    clr_hold = 0;
    cq[0].push_back(mk(1, 64'h1, 1, 32'h12345679));
    run(50);
    chk("msix_nomatch", 64'(msix_intr), 64'd0);

    // Reset in the middle of a read burst
    lat_lo = 2; lat_hi = 2;
    cq[2].push_back(mk(0, 64'h3000, 4, 32'h0));
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 60 && !hit; k++) begin
        cycle();
        if (m_busy && m_rem == 3) hit = 1;
      end
      chk("mid_burst_reached", 64'(hit), 64'd1);
    end
    do_reset();
    grant_log.delete();
    cq[1].push_back(mk(1, 64'h5000, 1, 32'h1));
    cq[3].push_back(mk(1, 64'h6000, 1, 32'h3));
    run(50);
    chk("post_reset_grant", 64'(grant_log[0]), 64'd1);

    // Randomised traffic
    do_reset();
    p_ready = 70; p_drop = 10; p_spur = 10; p_clr = 5; lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 60; n++) begin
      int   r;
      cmd_t c;
      r = $urandom_range(N - 1);
      c = mk(1'($urandom_range(1)), {$urandom, $urandom} & ~64'h3, $urandom_range(6), $urandom);
      if ($urandom_range(7) == 0) c.addr = 64'hFFFF_FFFF_FFFF_FFF8;
      if ($urandom_range(9) == 0)
        c = mk(1, 64'h1, $urandom_range(2), $urandom_range(1) ? 32'h12345678 : 32'h12345679);
      cq[r].push_back(c);
    end
    run(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
